// File: rtl/pa_rvfpm_pkg.sv
// rtl/pa_rvfpm_pkg.sv - shared FPU model widths, result-entry type and head-state encoding
package pa_rvfpm;

  localparam int X_ID_WIDTH    = 4;
  localparam int FLEN          = 32;
  localparam int FPU_RES_DEPTH = 4;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [FLEN-1:0]       data;
    logic [4:0]            rd;
    logic                  we;
    logic [4:0]            fflags;
  } fpu_res_entry_t;

  typedef enum logic [1:0] {
    HEAD_EMPTY,
    HEAD_WAIT,
    HEAD_DROP,
    HEAD_OFFER
  } head_state_e;

endpackage

// File: rtl/fpu_result_commit_buffer_fifo.sv
// rtl/fpu_result_commit_buffer_fifo.sv - generic circular FIFO with occupancy count
module fpu_res_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         ck,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CW'(DEPTH));
  assign do_push   = push && !full;
  assign do_pop    = pop && (count != '0);
  assign head_data = mem[rd_ptr];

  // Entry storage needs no reset: nothing reads it while count is zero.
  always_ff @(posedge ck) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_result_commit_buffer.sv
// rtl/fpu_result_commit_buffer.sv - holds FPU results until commit/kill, returns committed ones in order
module fpu_result_commit_buffer #(
  parameter int DEPTH      = pa_rvfpm::FPU_RES_DEPTH,
  parameter int X_ID_WIDTH = pa_rvfpm::X_ID_WIDTH,
  parameter int FLEN       = pa_rvfpm::FLEN
) (
  input  logic                         ck,
  input  logic                         rst_n,
  input  logic                         wb_valid,
  output logic                         wb_ready,
  input  logic [X_ID_WIDTH-1:0]        wb_id,
  input  logic [FLEN-1:0]              wb_data,
  input  logic [4:0]                   wb_rd,
  input  logic                         wb_we,
  input  logic [4:0]                   wb_fflags,
  input  logic                         commit_valid,
  input  logic [X_ID_WIDTH-1:0]        commit_id,
  input  logic                         commit_kill,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic [X_ID_WIDTH-1:0]        result_id,
  output logic [FLEN-1:0]              result_data,
  output logic [4:0]                   result_rd,
  output logic                         result_we,
  output logic [4:0]                   result_fflags,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  import pa_rvfpm::*;

  localparam int IDN = 1 << X_ID_WIDTH;
  localparam int CW  = $clog2(DEPTH+1);

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [FLEN-1:0]       data;
    logic [4:0]            rd;
    logic                  we;
    logic [4:0]            fflags;
  } entry_t;

  entry_t          push_entry;
  entry_t          head;
  logic [CW-1:0]   count;
  logic            full;
  logic            pop;
  logic [IDN-1:0]  cmt;
  logic [IDN-1:0]  kil;
  logic            offered;
  head_state_e     head_state;

  assign push_entry = '{id: wb_id, data: wb_data, rd: wb_rd, we: wb_we, fflags: wb_fflags};
  assign wb_ready   = !full;
  assign occupancy  = count;

  fpu_res_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .ck        (ck),
    .rst_n     (rst_n),
    .push      (wb_valid && wb_ready),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head),
    .count     (count),
    .full      (full)
  );

  // Once offered, the head stays offered regardless of later scoreboard changes.
  always_comb begin
    head_state = HEAD_EMPTY;
    if (count != '0) begin
      if (offered)            head_state = HEAD_OFFER;
      else if (kil[head.id])  head_state = HEAD_DROP;
      else if (cmt[head.id])  head_state = HEAD_OFFER;
      else                    head_state = HEAD_WAIT;
    end
  end

  assign result_valid  = (head_state == HEAD_OFFER);
  assign pop           = (head_state == HEAD_DROP) || (result_valid && result_ready);
  assign result_id     = result_valid ? head.id     : '0;
  assign result_data   = result_valid ? head.data   : '0;
  assign result_rd     = result_valid ? head.rd     : '0;
  assign result_we     = result_valid && head.we;
  assign result_fflags = result_valid ? head.fflags : '0;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      offered <= 1'b0;
    end else begin
      offered <= result_valid && !result_ready;
    end
  end

  // The clear is written last so a pop beats a same-cycle commit for the same ID.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      cmt <= '0;
      kil <= '0;
    end else begin
      if (commit_valid) begin
        if (commit_kill) kil[commit_id] <= 1'b1;
        else             cmt[commit_id] <= 1'b1;
      end
      if (pop) begin
        cmt[head.id] <= 1'b0;
        kil[head.id] <= 1'b0;
      end
    end
  end

endmodule
